// File: rtl/heichips25_pin_driver_pkg.sv
// Shared definitions for the tile pin driver: opcodes, FSM states,
// default response codes and small decode helpers.
// Optional feature macro: HEICHIPS25_PIN_DRIVER_CONTENTION_EN
package heichips25_pin_driver_pkg;

    localparam int         DEF_RST_CNT_W = 8;
    localparam logic [7:0] DEF_ACK_CODE  = 8'hA5;
    localparam logic [7:0] DEF_ERR_CODE  = 8'hEE;

    typedef enum logic [7:0] {
        OP_WRITE_UI  = 8'h01,
        OP_WRITE_UIO = 8'h02,
        OP_READ_UO   = 8'h03,
        OP_READ_UIO  = 8'h04,
        OP_READ_OE   = 8'h05,
        OP_TRST      = 8'h07,
        OP_SET_MASK  = 8'h08,
        OP_READ_CONT = 8'h09
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARG  = 2'd1,
        ST_RSP  = 2'd2,
        ST_TRST = 2'd3
    } state_e;

    // Opcodes that are followed by an operand byte.
    function automatic logic op_has_arg(input logic [7:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_WRITE_UI, OP_WRITE_UIO, OP_TRST: r = 1'b1;
`ifdef HEICHIPS25_PIN_DRIVER_CONTENTION_EN
            OP_SET_MASK: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // What the bidirectional pins look like: tile-driven bits come from the
    // tile, the rest from what the host is driving.
    function automatic logic [7:0] uio_readback(input logic [7:0] tile_val,
                                                input logic [7:0] host_val,
                                                input logic [7:0] oe);
        return (tile_val & oe) | (host_val & ~oe);
    endfunction

endpackage

// File: rtl/heichips25_pin_driver_cmd_fsm.sv
// Command-channel FSM for the tile pin driver, including the tile-reset
// pulse counter. Handshake outputs are registered.
// Optional feature macro: HEICHIPS25_PIN_DRIVER_CONTENTION_EN (via op_has_arg)
module heichips25_pin_driver_cmd_fsm
    import heichips25_pin_driver_pkg::*;
#(
    parameter int RST_CNT_W = DEF_RST_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    input  logic       rsp_ready,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic       op_fire,
    output logic       arg_fire,
    output logic [7:0] opcode,
    output state_e     next_state
);

    state_e               state_r;
    state_e               state_s;
    logic [RST_CNT_W-1:0] cnt_r;
    logic [RST_CNT_W-1:0] cnt_s;
    logic [7:0]           opcode_r;
    logic                 cmd_ready_r;
    logic                 rsp_valid_r;
    logic                 accept_s;
    logic                 op_fire_s;
    logic                 arg_fire_s;

    assign accept_s = cmd_valid & cmd_ready_r;

    // Next-state decode, pulse-counter update and byte-accept strobes.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        op_fire_s  = 1'b0;
        arg_fire_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    op_fire_s = 1'b1;
                    if (op_has_arg(cmd_data)) begin
                        state_s = ST_ARG;
                    end else begin
                        state_s = ST_RSP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARG: begin
                if (accept_s) begin
                    arg_fire_s = 1'b1;
                    if (opcode_r == OP_TRST) begin
                        state_s = ST_TRST;
                        // Counter holds remaining low cycles minus one; n=0 acts as 1.
                        if (cmd_data == 8'h00) begin
                            cnt_s = {RST_CNT_W{1'b0}};
                        end else begin
                            cnt_s = RST_CNT_W'(cmd_data - 8'd1);
                        end
                    end else begin
                        state_s = ST_RSP;
                    end
                end else begin
                    state_s = ST_ARG;
                end
            end
            ST_TRST: begin
                if (cnt_r == {RST_CNT_W{1'b0}}) begin
                    state_s = ST_RSP;
                end else begin
                    cnt_s = cnt_r - RST_CNT_W'(1);
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RSP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counter, latched opcode and registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {RST_CNT_W{1'b0}};
            opcode_r    <= 8'h00;
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            if (op_fire_s) begin
                opcode_r <= cmd_data;
            end else begin
                opcode_r <= opcode_r;
            end
            cmd_ready_r <= (state_s == ST_IDLE) || (state_s == ST_ARG);
            rsp_valid_r <= (state_s == ST_RSP);
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign op_fire    = op_fire_s;
    assign arg_fire   = arg_fire_s;
    assign opcode     = opcode_r;
    assign next_state = state_s;

endmodule

// File: rtl/heichips25_pin_driver.sv
// Host-side driver for one user-project tile: byte command channel in,
// byte responses out, tile pin registers and tile reset/enable.
// Optional feature macro: HEICHIPS25_PIN_DRIVER_CONTENTION_EN adds the host
// drive mask (opcode 0x08) and the sticky contention flag (opcode 0x09).
module heichips25_pin_driver
    import heichips25_pin_driver_pkg::*;
#(
    parameter int         RST_CNT_W = DEF_RST_CNT_W,
    parameter logic [7:0] ACK_CODE  = DEF_ACK_CODE,
    parameter logic [7:0] ERR_CODE  = DEF_ERR_CODE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] tile_ui_in,
    output logic [7:0] tile_uio_in,
    output logic       tile_ena,
    output logic       tile_rst_n,
    input  logic [7:0] tile_uo_out,
    input  logic [7:0] tile_uio_out,
    input  logic [7:0] tile_uio_oe,
    output logic       contention
);

    state_e     next_state_s;
    logic       op_fire_s;
    logic       arg_fire_s;
    logic [7:0] opcode_s;
    logic [7:0] ui_r;
    logic [7:0] uio_r;
    logic       ena_r;
    logic       trst_n_r;
    logic [7:0] rsp_data_r;
    logic [7:0] rsp_data_s;
    logic       cont_r;

    heichips25_pin_driver_cmd_fsm #(
        .RST_CNT_W (RST_CNT_W)
    ) u_cmd_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .rsp_ready  (rsp_ready),
        .cmd_ready  (cmd_ready),
        .rsp_valid  (rsp_valid),
        .op_fire    (op_fire_s),
        .arg_fire   (arg_fire_s),
        .opcode     (opcode_s),
        .next_state (next_state_s)
    );

`ifdef HEICHIPS25_PIN_DRIVER_CONTENTION_EN
    logic [7:0] mask_r;
    logic       cont_set_s;
    logic       cont_clr_s;

    assign cont_set_s = |(tile_uio_oe & mask_r);
    assign cont_clr_s = op_fire_s && (cmd_data == OP_READ_CONT);

    // Host drive mask, written by the 0x08 operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r <= 8'hFF;
        end else if (arg_fire_s && (opcode_s == OP_SET_MASK)) begin
            mask_r <= cmd_data;
        end else begin
            mask_r <= mask_r;
        end
    end

    // Sticky contention flag; a set on the same edge beats the read-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_r <= 1'b0;
        end else if (cont_set_s) begin
            cont_r <= 1'b1;
        end else if (cont_clr_s) begin
            cont_r <= 1'b0;
        end else begin
            cont_r <= cont_r;
        end
    end
`else
    assign cont_r = 1'b0;
`endif

    // Response byte: reads sample pins on the opcode edge, writes ack on the operand edge.
    always_comb begin
        rsp_data_s = rsp_data_r;
        if (op_fire_s) begin
            case (cmd_data)
                OP_READ_UO:   rsp_data_s = tile_uo_out;
                OP_READ_UIO:  rsp_data_s = uio_readback(tile_uio_out, uio_r, tile_uio_oe);
                OP_READ_OE:   rsp_data_s = tile_uio_oe;
                OP_WRITE_UI,
                OP_WRITE_UIO,
                OP_TRST:      rsp_data_s = rsp_data_r;
`ifdef HEICHIPS25_PIN_DRIVER_CONTENTION_EN
                OP_SET_MASK:  rsp_data_s = rsp_data_r;
                OP_READ_CONT: rsp_data_s = {7'b0000000, cont_r};
`endif
                default:      rsp_data_s = ERR_CODE;
            endcase
        end else if (arg_fire_s) begin
            rsp_data_s = ACK_CODE;
        end else begin
            rsp_data_s = rsp_data_r;
        end
    end

    // Response data register; held while the response waits for the host.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_r <= 8'h00;
        end else begin
            rsp_data_r <= rsp_data_s;
        end
    end

    // Pin registers driving the tile dedicated and bidirectional inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ui_r  <= 8'h00;
            uio_r <= 8'h00;
        end else begin
            if (arg_fire_s && (opcode_s == OP_WRITE_UI)) begin
                ui_r <= cmd_data;
            end else begin
                ui_r <= ui_r;
            end
            if (arg_fire_s && (opcode_s == OP_WRITE_UIO)) begin
                uio_r <= cmd_data;
            end else begin
                uio_r <= uio_r;
            end
        end
    end

    // Tile enable and reset: both rise on the first edge out of reset,
    // reset drops while the FSM sits in the pulse state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_r    <= 1'b0;
            trst_n_r <= 1'b0;
        end else begin
            ena_r    <= 1'b1;
            trst_n_r <= (next_state_s != ST_TRST);
        end
    end

    assign rsp_data    = rsp_data_r;
    assign tile_ui_in  = ui_r;
    assign tile_uio_in = uio_r;
    assign tile_ena    = ena_r;
    assign tile_rst_n  = trst_n_r;
    assign contention  = cont_r;

endmodule

// File: tb/tb_heichips25_pin_driver.sv
// Self-checking bench for heichips25_pin_driver: directed scenarios plus
// randomized commands scored against a behavioural pin/response model.
module tb_heichips25_pin_driver;

    logic       clk;
    logic       rst_n;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] tile_ui_in;
    logic [7:0] tile_uio_in;
    logic       tile_ena;
    logic       tile_rst_n;
    logic [7:0] tile_uo_out;
    logic [7:0] tile_uio_out;
    logic [7:0] tile_uio_oe;
    logic       contention;

    int checks;
    int failures;

    // Behavioural model state
    logic [7:0] m_ui;
    logic [7:0] m_uio;
    logic [7:0] m_mask;
    bit         m_cont;

    heichips25_pin_driver dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_data     (cmd_data),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .rsp_data     (rsp_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .tile_ui_in   (tile_ui_in),
        .tile_uio_in  (tile_uio_in),
        .tile_ena     (tile_ena),
        .tile_rst_n   (tile_rst_n),
        .tile_uo_out  (tile_uo_out),
        .tile_uio_out (tile_uio_out),
        .tile_uio_oe  (tile_uio_oe),
        .contention   (contention)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_has_arg(input logic [7:0] op);
        bit r;
        r = (op == 8'h01) || (op == 8'h02) || (op == 8'h07);
`ifdef HEICHIPS25_PIN_DRIVER_CONTENTION_EN
        if (op == 8'h08) r = 1'b1;
`endif
        return r;
    endfunction

    // Expected response for an opcode given the current pins and model.
    function automatic logic [7:0] model_rsp(input logic [7:0] op);
        logic [7:0] r;
        case (op)
            8'h01, 8'h02, 8'h07: r = 8'hA5;
            8'h03: r = tile_uo_out;
            8'h04: begin
                for (int b = 0; b < 8; b++) begin
                    r[b] = tile_uio_oe[b] ? tile_uio_out[b] : m_uio[b];
                end
            end
            8'h05: r = tile_uio_oe;
`ifdef HEICHIPS25_PIN_DRIVER_CONTENTION_EN
            8'h08: r = 8'hA5;
            8'h09: r = {7'b0000000, m_cont};
`endif
            default: r = 8'hEE;
        endcase
        return r;
    endfunction

    // At least one clock edge has passed with the current oe/mask.
    task automatic m_edge();
`ifdef HEICHIPS25_PIN_DRIVER_CONTENTION_EN
        if ((tile_uio_oe & m_mask) != 8'h00) m_cont = 1'b1;
`endif
    endtask

    // Present one byte; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            check_eq("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    // Wait hold cycles with rsp_ready low, then take the response.
    task automatic get_rsp(output logic [7:0] d, input int hold);
        int n;
        n = 0;
        d = 8'h00;
        rsp_ready = 1'b0;
        repeat (hold) @(negedge clk);
        while (rsp_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (rsp_valid !== 1'b1) begin
            check_eq("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
        end else begin
            d = rsp_data;
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [7:0] arg, input int hold,
                           output logic [7:0] got);
        logic [7:0] exp;
        bit         has_arg;
        int         low;
        int         want;
        has_arg = m_has_arg(op);
        exp     = model_rsp(op);
        send_byte(op);
`ifdef HEICHIPS25_PIN_DRIVER_CONTENTION_EN
        if (op == 8'h09) m_cont = ((tile_uio_oe & m_mask) != 8'h00);
        else m_edge();
`endif
        if (!has_arg) begin
            check_eq("read_rsp_valid_latency", 32'(rsp_valid), 32'd1);
            // Pins move after the opcode edge; the response must not follow.
            tile_uo_out  = 8'($urandom);
            tile_uio_out = 8'($urandom);
        end else begin
            send_byte(arg);
            m_edge();
            if (op == 8'h01) m_ui = arg;
            if (op == 8'h02) m_uio = arg;
            if (op == 8'h08) m_mask = arg;
            check_eq("tile_ui_in", 32'(tile_ui_in), 32'(m_ui));
            check_eq("tile_uio_in", 32'(tile_uio_in), 32'(m_uio));
            if (op == 8'h07) begin
                low  = 0;
                want = (arg == 8'h00) ? 1 : int'(arg);
                while (tile_rst_n === 1'b0 && low < 300) begin
                    low++;
                    @(negedge clk);
                end
                check_eq("trst_low_cycles", 32'(low), 32'(want));
            end
            check_eq("write_rsp_valid_latency", 32'(rsp_valid), 32'd1);
        end
        get_rsp(got, hold);
        m_edge();
        check_eq("rsp_data", 32'(got), 32'(exp));
        check_eq("contention", 32'(contention), 32'(m_cont));
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst_ui", 32'(tile_ui_in), 32'd0);
        check_eq("rst_uio", 32'(tile_uio_in), 32'd0);
        check_eq("rst_ena", 32'(tile_ena), 32'd0);
        check_eq("rst_tile_rst_n", 32'(tile_rst_n), 32'd0);
        check_eq("rst_contention", 32'(contention), 32'd0);
    endtask

    // Assert reset at a negedge, check outputs at once, release and check rise.
    task automatic do_reset();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        m_ui   = 8'h00;
        m_uio  = 8'h00;
        m_mask = 8'hFF;
        m_cont = 1'b0;
        rst_n  = 1'b1;
        #1;
        check_eq("ena_before_edge", 32'(tile_ena), 32'd0);
        check_eq("ready_before_edge", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check_eq("ena_rise", 32'(tile_ena), 32'd1);
        check_eq("tile_rst_n_rise", 32'(tile_rst_n), 32'd1);
        check_eq("ready_rise", 32'(cmd_ready), 32'd1);
        m_edge();
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] op;
        logic [7:0] arg;
        int         idx;
        logic [7:0] op_tbl [0:7];
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        cmd_data     = 8'h00;
        cmd_valid    = 1'b0;
        rsp_ready    = 1'b0;
        tile_uo_out  = 8'h00;
        tile_uio_out = 8'h00;
        tile_uio_oe  = 8'h00;
        m_ui = 8'h00; m_uio = 8'h00; m_mask = 8'hFF; m_cont = 1'b0;
        op_tbl[0] = 8'h01; op_tbl[1] = 8'h02; op_tbl[2] = 8'h03; op_tbl[3] = 8'h04;
        op_tbl[4] = 8'h05; op_tbl[5] = 8'h07; op_tbl[6] = 8'h08; op_tbl[7] = 8'h09;

        @(negedge clk);
        do_reset();

        // Write UI
        run_cmd(8'h01, 8'h3C, 0, got);
        check_eq("ui_ack", 32'(got), 32'hA5);
        check_eq("ui_3c", 32'(tile_ui_in), 32'h3C);

        // Write UIO then read back the mixed pins
        tile_uio_oe  = 8'h0F;
        tile_uio_out = 8'h05;
        run_cmd(8'h02, 8'hF0, 1, got);
        run_cmd(8'h04, 8'h00, 0, got);
        check_eq("uio_readback_f5", 32'(got), 32'hF5);

        // Tile reset pulses
        run_cmd(8'h07, 8'h03, 0, got);
        run_cmd(8'h07, 8'h00, 2, got);

        // Response held while the host stalls
        tile_uo_out = 8'h6B;
        send_byte(8'h03);
        m_edge();
        tile_uo_out = 8'h00;
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_rsp_data", 32'(rsp_data), 32'h6B);
            check_eq("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        get_rsp(got, 0);
        m_edge();
        check_eq("hold_final", 32'(got), 32'h6B);

        // Unknown opcode, then the next byte is a fresh opcode
        run_cmd(8'h55, 8'h00, 0, got);
        check_eq("unknown_err", 32'(got), 32'hEE);
        tile_uo_out = 8'h81;
        run_cmd(8'h03, 8'h00, 0, got);
        check_eq("after_unknown", 32'(got), 32'h81);

        // Reset during the tile-reset pulse
        tile_uio_oe = 8'h00;
        send_byte(8'h07);
        send_byte(8'h40);
        repeat (3) @(negedge clk);
        check_eq("mid_trst_low", 32'(tile_rst_n), 32'd0);
        do_reset();

        // Reset while a response is pending
        send_byte(8'h03);
        repeat (2) @(negedge clk);
        check_eq("mid_rsp_valid", 32'(rsp_valid), 32'd1);
        do_reset();
        tile_uio_oe = 8'h3A;
        run_cmd(8'h05, 8'h00, 0, got);
        check_eq("oe_after_reset", 32'(got), 32'h3A);

`ifdef HEICHIPS25_PIN_DRIVER_CONTENTION_EN
        tile_uio_oe = 8'h80;
        run_cmd(8'h08, 8'h80, 0, got);
        tile_uio_oe = 8'h00;
        run_cmd(8'h09, 8'h00, 0, got);
        check_eq("cont_first_read", 32'(got), 32'h01);
        run_cmd(8'h09, 8'h00, 0, got);
        check_eq("cont_second_read", 32'(got), 32'h00);
`else
        run_cmd(8'h09, 8'h00, 0, got);
        check_eq("no_cont_err", 32'(got), 32'hEE);
        run_cmd(8'h08, 8'h12, 0, got);
        check_eq("no_mask_err", 32'(got), 32'hEE);
`endif

        // Randomized traffic against the model
        for (int it = 0; it < 80; it++) begin
            idx = $urandom_range(0, 8);
            if (idx == 8) op = 8'($urandom);
            else op = op_tbl[idx];
            if (op == 8'h07) arg = 8'($urandom_range(0, 12));
            else arg = 8'($urandom);
            tile_uo_out  = 8'($urandom);
            tile_uio_out = 8'($urandom);
            tile_uio_oe  = 8'($urandom);
            run_cmd(op, arg, $urandom_range(0, 3), got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
